// File: rtl/dm_port_arbiter.sv
// Shares one data memory between the CPU MEM stage and a word-copy DMA engine.
// Latency: grant and memory mux are combinational; DMA read data returns registered one cycle after grant.
// Backpressure: a losing CPU is stalled; the DMA holds its request until granted, forced in after STARVE_MAX contended losses.
module dm_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [4:0]  cpu_load_ctrl,
    input  logic [4:0]  cpu_save_ctrl,
    input  logic [31:0] cpu_pc,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dm_wen,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [31:0] dm_pc,
    output logic [4:0]  dm_load_ctrl,
    output logic [4:0]  dm_save_ctrl,
    input  logic [31:0] dm_dout,
    output logic        owner,
    output logic [3:0]  starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} owner_e;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] pc;
        logic [4:0]  load_ctrl;
        logic [4:0]  save_ctrl;
    } mem_req_t;

    owner_e      owner_q, owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_gnt;
    mem_req_t    mem;

    // DMA byte-lane bits are meaningless for word transfers.
    logic unused_dma_addr_lo;
    assign unused_dma_addr_lo = &{1'b0, dma_addr[1:0]};

    always_comb begin
        dma_gnt = dma_req & (~cpu_req | (starve_cnt_q == STARVE_LIM));
        cpu_gnt = cpu_req & ~dma_gnt;

        mem = '{wen: 1'b0, addr: cpu_addr, din: cpu_wdata, pc: cpu_pc,
                load_ctrl: 5'd0, save_ctrl: 5'd0};
        if (dma_gnt) begin
            mem.wen       = dma_we;
            mem.addr      = {dma_addr[31:2], 2'b00};
            mem.din       = dma_wdata;
            mem.pc        = 32'd0;
            mem.load_ctrl = dma_we ? 5'd0 : 5'd5;
            mem.save_ctrl = dma_we ? 5'd3 : 5'd0;
        end else if (cpu_gnt) begin
            mem.wen       = cpu_we & (cpu_save_ctrl != 5'd0);
            mem.load_ctrl = cpu_load_ctrl;
            mem.save_ctrl = cpu_save_ctrl;
        end

        starve_cnt_d = starve_cnt_q;
        if (dma_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (cpu_gnt && dma_req) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
        end

        owner_d = owner_q;
        if (cpu_gnt) begin
            owner_d = S_CPU;
        end else if (dma_gnt) begin
            owner_d = S_DMA;
        end

        dma_rvalid_d = dma_gnt & ~dma_we;
        dma_rdata_d  = dma_rvalid_d ? dm_dout : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= S_CPU;
            starve_cnt_q <= 4'd0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= 32'd0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_stall    = cpu_req & ~cpu_gnt;
    assign cpu_rdata    = dm_dout;
    assign dma_rvalid   = dma_rvalid_q;
    assign dma_rdata    = dma_rdata_q;
    assign dm_wen       = mem.wen;
    assign dm_addr      = mem.addr;
    assign dm_din       = mem.din;
    assign dm_pc        = mem.pc;
    assign dm_load_ctrl = mem.load_ctrl;
    assign dm_save_ctrl = mem.save_ctrl;
    assign owner        = owner_q;
    assign starve_cnt   = starve_cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: rule-level model checked every cycle plus directed literal checks.
module tb_dm_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
    logic [4:0]  cpu_load_ctrl, cpu_save_ctrl;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dm_wen;
    logic [31:0] dm_addr, dm_din, dm_pc, dm_dout;
    logic [4:0]  dm_load_ctrl, dm_save_ctrl;
    logic        owner;
    logic [3:0]  starve_cnt;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    dm_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_load_ctrl(cpu_load_ctrl), .cpu_save_ctrl(cpu_save_ctrl), .cpu_pc(cpu_pc),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_din(dm_din), .dm_pc(dm_pc),
        .dm_load_ctrl(dm_load_ctrl), .dm_save_ctrl(dm_save_ctrl), .dm_dout(dm_dout),
        .owner(owner), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: contended CPU wins since the DMA last got in, last owner, read return.
    int          m_losses = 0;
    bit          m_owner_dma = 1'b0;
    bit          m_rv = 1'b0;
    logic [31:0] m_rd = 32'd0;

    function automatic bit dma_wins();
        if (!dma_req) return 1'b0;
        if (!cpu_req) return 1'b1;
        return m_losses == SM;
    endfunction

    always @(posedge clk) begin
        bit dw, cw;
        dw = dma_wins();
        cw = cpu_req && !dw;
        if (reset) begin
            m_losses = 0; m_owner_dma = 1'b0; m_rv = 1'b0; m_rd = 32'd0;
        end else begin
            if (dw) m_losses = 0;
            else if (cw && dma_req && m_losses < SM) m_losses = m_losses + 1;
            if (dw) m_owner_dma = 1'b1;
            else if (cw) m_owner_dma = 1'b0;
            m_rv = dw && !dma_we;
            if (m_rv) m_rd = dm_dout;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            bit dw, cw;
            dw = dma_wins();
            cw = cpu_req && !dw;
            chk("m_dma_gnt", {31'd0, dma_gnt}, {31'd0, dw});
            chk("m_cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !cw});
            chk("m_cpu_rdata", cpu_rdata, dm_dout);
            chk("m_dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rv});
            chk("m_dma_rdata", dma_rdata, m_rd);
            chk("m_starve_cnt", {28'd0, starve_cnt}, 32'(m_losses));
            chk("m_owner", {31'd0, owner}, {31'd0, m_owner_dma});
            if (dw) begin
                chk("m_dm_addr", dm_addr, dma_addr & 32'hFFFF_FFFC);
                chk("m_dm_din", dm_din, dma_wdata);
                chk("m_dm_pc", dm_pc, 32'd0);
                chk("m_dm_wen", {31'd0, dm_wen}, {31'd0, dma_we});
                chk("m_dm_load", {27'd0, dm_load_ctrl}, dma_we ? 32'd0 : 32'd5);
                chk("m_dm_save", {27'd0, dm_save_ctrl}, dma_we ? 32'd3 : 32'd0);
            end else begin
                chk("m_dm_addr", dm_addr, cpu_addr);
                chk("m_dm_din", dm_din, cpu_wdata);
                chk("m_dm_pc", dm_pc, cpu_pc);
                chk("m_dm_wen", {31'd0, dm_wen}, {31'd0, cw && cpu_we && cpu_save_ctrl != 5'd0});
                chk("m_dm_load", {27'd0, dm_load_ctrl}, cw ? {27'd0, cpu_load_ctrl} : 32'd0);
                chk("m_dm_save", {27'd0, dm_save_ctrl}, cw ? {27'd0, cpu_save_ctrl} : 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_pc = 0;
        cpu_load_ctrl = 0; cpu_save_ctrl = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dm_dout = 32'h0BAD_F00D;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic cpu_lw(input logic [31:0] a);
        cpu_req = 1; cpu_we = 0; cpu_addr = a; cpu_load_ctrl = 5; cpu_save_ctrl = 0; cpu_pc = 32'h100;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        cpu_lw(32'h4);
        dma_req = 1; dma_we = 0; dma_addr = 32'h8;
        tick();
        run = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk("rst_starve", {28'd0, starve_cnt}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        tick();
        do_reset();

        // CPU store word
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        cpu_save_ctrl = 3; cpu_pc = 32'h3000;
        #1;
        chk("sw_wen", {31'd0, dm_wen}, 32'd1);
        chk("sw_save", {27'd0, dm_save_ctrl}, 32'd3);
        chk("sw_pc", dm_pc, 32'h3000);
        chk("sw_addr", dm_addr, 32'h10);
        chk("sw_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("sw_stall", {31'd0, cpu_stall}, 32'd0);
        tick();

        // DMA read alone
        clear_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 32'h13; dm_dout = 32'h12345678;
        #1;
        chk("dr_addr", dm_addr, 32'h10);
        chk("dr_load", {27'd0, dm_load_ctrl}, 32'd5);
        chk("dr_gnt", {31'd0, dma_gnt}, 32'd1);
        tick();
        dma_req = 0; dm_dout = 32'h55550000;
        #1;
        chk("dr_rvalid1", {31'd0, dma_rvalid}, 32'd1);
        chk("dr_rdata", dma_rdata, 32'h12345678);
        chk("dr_gnt_off", {31'd0, dma_gnt}, 32'd0);
        tick();
        #1;
        chk("dr_rvalid0", {31'd0, dma_rvalid}, 32'd0);
        chk("dr_rdata_hold", dma_rdata, 32'h12345678);

        // Reset lands on a DMA-read grant cycle: data dropped
        reset = 1; dma_req = 1; dma_we = 0; dma_addr = 32'h40; dm_dout = 32'hA5A5A5A5;
        #1;
        chk("rg_gnt", {31'd0, dma_gnt}, 32'd1);
        tick();
        reset = 0; dma_req = 0;
        #1;
        chk("rg_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rg_rdata", dma_rdata, 32'd0);
        tick();

        // Continuous contention, DMA forced in on cycle SM
        cpu_lw(32'h200);
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE0000;
        for (int c = 0; c < SM; c++) begin
            #1;
            chk("ct_cpu_stall", {31'd0, cpu_stall}, 32'd0);
            chk("ct_dma_gnt", {31'd0, dma_gnt}, 32'd0);
            tick();
        end
        #1;
        chk("ct_force_gnt", {31'd0, dma_gnt}, 32'd1);
        chk("ct_force_stall", {31'd0, cpu_stall}, 32'd1);
        chk("ct_force_din", dm_din, 32'hCAFE0000);
        chk("ct_force_wen", {31'd0, dm_wen}, 32'd1);
        chk("ct_force_cnt", {28'd0, starve_cnt}, 32'd4);
        tick();
        dma_we = 0; dma_addr = 32'h24;
        #1;
        chk("ct_c5_stall", {31'd0, cpu_stall}, 32'd0);
        chk("ct_c5_cnt", {28'd0, starve_cnt}, 32'd0);
        tick();
        #1;
        chk("ct_c6_cnt", {28'd0, starve_cnt}, 32'd1);
        tick();
        do_reset();

        // Two CPU wins, idle cycle, then DMA in after two more contended cycles
        cpu_lw(32'h300);
        dma_req = 1; dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'h0000_1111;
        tick();
        tick();
        cpu_req = 0; dma_req = 0;
        #1;
        chk("ib_idle_cnt", {28'd0, starve_cnt}, 32'd2);
        tick();
        cpu_req = 1; dma_req = 1;
        #1;
        chk("ib_cnt2", {28'd0, starve_cnt}, 32'd2);
        chk("ib_gnt_a", {31'd0, dma_gnt}, 32'd0);
        tick();
        #1;
        chk("ib_cnt3", {28'd0, starve_cnt}, 32'd3);
        chk("ib_gnt_b", {31'd0, dma_gnt}, 32'd0);
        tick();
        #1;
        chk("ib_gnt_c", {31'd0, dma_gnt}, 32'd1);
        tick();
        clear_inputs();
        tick();
        tick();
        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
